// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the parametrised register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width / address width
//   cnt_width()             : width of the pending-register counter
package reg_file_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   // The counter has to hold the value DEPTH itself, which needs one bit more than an address.
   function automatic int unsigned cnt_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, operand-ready logic
// for two read ports and a running count of pending registers.
//   clk, reset                  : clock, async active-low reset
//   Reg_Write_i/Write_Register_i: writeback port (clears pending)
//   Rsv_Valid_i/Rsv_Register_i  : reservation port (sets pending)
//   Flush_i                     : clear every pending bit
//   Read_Register_k_i           : read addresses
//   Read_Ready_k_o              : operand ready (combinational)
//   Pending_Cnt_o               : number of pending registers (registered)
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         Reg_Write_i,
   input  logic [ADDR_W-1:0]            Write_Register_i,
   input  logic                         Rsv_Valid_i,
   input  logic [ADDR_W-1:0]            Rsv_Register_i,
   input  logic                         Flush_i,
   input  logic [ADDR_W-1:0]            Read_Register_1_i,
   input  logic [ADDR_W-1:0]            Read_Register_2_i,
   output logic                         Read_Ready_1_o,
   output logic                         Read_Ready_2_o,
   output logic [cnt_width(ADDR_W)-1:0] Pending_Cnt_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = cnt_width(ADDR_W);

   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic rsv_eff_c;
   logic inc_c;
   logic dec_c;

   // A reservation takes effect unless flushed or aimed at the hardwired zero register.
   assign rsv_eff_c = Rsv_Valid_i && !Flush_i
                      && !(ZERO_REG && (Rsv_Register_i == '0));

   // Counter steps only on real transitions; a write that lands on the register
   // being re-reserved the same cycle leaves it pending, so it is not a decrement.
   assign inc_c = rsv_eff_c && !pend_q[Rsv_Register_i];
   assign dec_c = Reg_Write_i && pend_q[Write_Register_i]
                  && !(rsv_eff_c && (Rsv_Register_i == Write_Register_i));

   // Next pending vector and count; reserve is applied after write so it wins on a tie.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (Flush_i) begin
         pend_d = '0;
         cnt_d  = '0;
      end else begin
         if (Reg_Write_i) begin
            pend_d[Write_Register_i] = 1'b0;
         end
         if (rsv_eff_c) begin
            pend_d[Rsv_Register_i] = 1'b1;
         end
         if (inc_c && !dec_c) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (dec_c && !inc_c) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   // Ready: not pending, being written back this cycle, or the zero register.
   always_comb begin
      Read_Ready_1_o = !pend_q[Read_Register_1_i]
                       || (Reg_Write_i && (Write_Register_i == Read_Register_1_i))
                       || (ZERO_REG && (Read_Register_1_i == '0));
      Read_Ready_2_o = !pend_q[Read_Register_2_i]
                       || (Reg_Write_i && (Write_Register_i == Read_Register_2_i))
                       || (ZERO_REG && (Read_Register_2_i == '0));
   end

   assign Pending_Cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard for issue stalls.
//   clk, reset                  : clock, async active-low reset
//   Reg_Write_i, Write_Register_i, Write_Data_i : writeback port
//   Rsv_Valid_i, Rsv_Register_i : reservation port
//   Flush_i                     : squash all pending reservations
//   Read_Register_k_i           : read addresses (two ports)
//   Read_Data_k_o               : read data (combinational, bypassed)
//   Read_Ready_k_o              : operand ready (combinational)
//   Pending_Cnt_o               : number of pending registers (registered)
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         Reg_Write_i,
   input  logic [ADDR_W-1:0]            Write_Register_i,
   input  logic [DATA_W-1:0]            Write_Data_i,
   input  logic                         Rsv_Valid_i,
   input  logic [ADDR_W-1:0]            Rsv_Register_i,
   input  logic                         Flush_i,
   input  logic [ADDR_W-1:0]            Read_Register_1_i,
   input  logic [ADDR_W-1:0]            Read_Register_2_i,
   output logic [DATA_W-1:0]            Read_Data_1_o,
   output logic [DATA_W-1:0]            Read_Data_2_o,
   output logic                         Read_Ready_1_o,
   output logic                         Read_Ready_2_o,
   output logic [cnt_width(ADDR_W)-1:0] Pending_Cnt_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_ok_c;

   // Writes to the hardwired zero register are dropped.
   assign wr_ok_c = Reg_Write_i && !(ZERO_REG && (Write_Register_i == '0));

   // Register storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok_c) begin
         mem_q[Write_Register_i] <= Write_Data_i;
      end
   end

   // Read port mux: zero register, then same-cycle bypass, then storage.
   function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] stored);
      logic [DATA_W-1:0] val;
      val = stored;
      if (Reg_Write_i && (Write_Register_i == addr)) begin
         val = Write_Data_i;
      end
      if (ZERO_REG && (addr == '0)) begin
         val = '0;
      end
      return val;
   endfunction

   always_comb begin
      Read_Data_1_o = read_sel(Read_Register_1_i, mem_q[Read_Register_1_i]);
      Read_Data_2_o = read_sel(Read_Register_2_i, mem_q[Read_Register_2_i]);
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk               (clk),
      .reset             (reset),
      .Reg_Write_i       (Reg_Write_i),
      .Write_Register_i  (Write_Register_i),
      .Rsv_Valid_i       (Rsv_Valid_i),
      .Rsv_Register_i    (Rsv_Register_i),
      .Flush_i           (Flush_i),
      .Read_Register_1_i (Read_Register_1_i),
      .Read_Register_2_i (Read_Register_2_i),
      .Read_Ready_1_o    (Read_Ready_1_o),
      .Read_Ready_2_o    (Read_Ready_2_o),
      .Pending_Cnt_o     (Pending_Cnt_o)
   );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a per-register pending-write scoreboard. It serves as the successor to the fixed 32×32 register file in the datapath. It adds configurable width and depth, a hardwired zero register, write-to-read bypass, and reservation tracking so that issue logic can stall on registers whose producer has not yet written back. It sits between decode/issue (reservations, reads) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or reserved

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk upstream
- Reg_Write_i  in  1  write enable
- Write_Register_i  in  ADDR_W  write address
- Write_Data_i  in  DATA_W  write data
- Rsv_Valid_i  in  1  reserve request: mark Rsv_Register_i pending
- Rsv_Register_i  in  ADDR_W  register to reserve
- Flush_i  in  1  clear every pending bit (squash of in-flight producers)
- Read_Register_1_i / Read_Register_2_i  in  ADDR_W  read addresses
- Read_Data_1_o / Read_Data_2_o  out  DATA_W  read data, combinational
- Read_Ready_1_o / Read_Ready_2_o  out  1  operand valid: not pending, or bypassed this cycle
- Pending_Cnt_o  out  ADDR_W+1  number of pending registers, registered

## Operation
- Storage is DEPTH × DATA_W. On a rising clk edge with Reg_Write_i=1, Write_Register_i is loaded with Write_Data_i. A write to register 0 is dropped when ZERO_REG=1.
- Reads are combinational. Read_Data_k_o selects the following, in priority order:
  1. 0 if ZERO_REG and the address is 0.
  2. Write_Data_i if Reg_Write_i and Write_Register_i equals the read address (bypass).
  3. The stored value.
- Scoreboard keeps one pending bit per register. Each edge updates it as follows:
  - Write clears the pending bit of Write_Register_i.
  - Reserve sets the pending bit of Rsv_Register_i.
  - A write and a reserve to the same address in the same cycle leave the bit set (the new producer wins).
  - Reserve to register 0 is ignored when ZERO_REG=1.
  - Flush_i=1 clears all bits. A reserve in the same cycle is ignored. A write in the same cycle still updates storage.
- Read_Ready_k_o = !pending[addr] | (Reg_Write_i & Write_Register_i==addr) | (ZERO_REG & addr==0).
- Pending_Cnt_o equals the popcount of the pending bits after each edge. It is maintained incrementally: +1 for a reserve of a non-pending register, −1 for a write clearing a pending register, 0 when both occur or neither takes effect. Flush loads 0. It never exceeds DEPTH−ZERO_REG.

## Timing
- Reset (reset=0, asynchronous) clears all storage to 0, all pending bits to 0, and Pending_Cnt_o to 0. While reset is asserted, Read_Data outputs reflect zeroed storage, or the bypass value if Reg_Write_i is active; Read_Ready outputs are 1.
- Write latency: same cycle via bypass; stored value from the next cycle.
- Reserve latency: the pending bit and Read_Ready=0 are visible the cycle after Rsv_Valid_i.
- Reset asserted mid-operation discards all pending reservations and data immediately. No write is committed on the edge during reset.
- Address inputs are unconstrained. All DEPTH addresses are valid, with no wrap or out-of-range case.

## Structure
- Package reg_file_pkg holds the DATA_W/ADDR_W defaults and a function computing Pending_Cnt width.
- One sub-module, reg_scoreboard, covers the pending bits, ready logic and counter. The top level holds storage and the read muxes/bypass.

## Test plan
- Reset, then write 0xDEADBEEF to r5 → same cycle Read_Data_1_o=0xDEADBEEF (bypass) with Read_Register_1_i=5; next cycle stored value 0xDEADBEEF.
- Write 0x1234 to r0 with ZERO_REG=1 → Read_Data on r0 is 0 in the same and next cycle; Rsv r0 → Pending_Cnt_o stays 0.
- Reserve r3, then r7 → Pending_Cnt_o=1, then 2; Read_Ready on r3 is 0. Write r3 → Read_Ready=1 in the write cycle and Pending_Cnt_o=1 after.
- Same-cycle write and reserve of r9 (r9 pending) → r9 stays pending, data updated, Pending_Cnt_o unchanged.
- Reserve r1, r2, r4, then Flush_i alongside a reserve of r6 and a write of 0xAA to r2 → Pending_Cnt_o=0, all ready, r2=0xAA, r6 not pending.
- Reserve r10 and write r11=0x55, then drop reset mid-cycle → immediate zero storage, Pending_Cnt_o=0, r11 reads 0 after release.
